mcycle_decoder: RTL and testbench
=================================

MCYCLE_DECODER -- requirements
Module: mcycle_decoder

Interface
REQ-001 Parameter WIDTH, default 8: memory data-path width in bits, legal values 8, 16 and 32.
REQ-002 Parameter EXT_OPS, default 1: when 1, BNE, ANDI and ORI are decoded; when 0, they are illegal.
REQ-003 Derived constant BEATS = 32/WIDTH: number of memory beats per 32-bit word.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 instr  in  32  contents of the instruction register.
REQ-007 mem_rdy  in  1  memory beat completes this cycle.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 state  out  4  current FSM state code.
REQ-010 irwrite  out  BEATS  one-hot instruction-register beat enable.
REQ-011 memread, memwrite, iord, memtoreg, regwrite, regdst  out  1 each  datapath controls.
REQ-012 pcwrite  out  1  PC update enable, already qualified by the branch condition.
REQ-013 pcsrc  out  2  PC source select: 00 ALU, 01 ALUOut, 10 jump target.
REQ-014 alusrca  out  1  ALU A select: 0 PC, 1 register.
REQ-015 alusrcb  out  2  ALU B select: 00 reg, 01 beat increment, 10 imm_ext, 11 imm_ext<<2.
REQ-016 alucont  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-017 imm_ext  out  32  extended instr[15:0].
REQ-018 beat  out  log2(BEATS), minimum width 1  current memory beat index.
REQ-019 illegal  out  1  one-cycle pulse when an undecodable opcode is seen.

Function
REQ-020 States: FETCH, DECODE, MEMADR, LDRD, LDWB, STWR, RTYPEEX, RTYPEWB, BREX, IMMEX, IMMWB, JEX.
REQ-021 FETCH: memread=1, iord=0, irwrite[beat]=mem_rdy, alusrca=0, alusrcb=01, alucont=010, pcwrite=mem_rdy, pcsrc=00.
REQ-022 FETCH: PC increment per beat is WIDTH/8; after the last beat with mem_rdy=1, go to DECODE and clear beat.
REQ-023 In any memory state with mem_rdy=0: hold state and beat; irwrite, pcwrite and regwrite are all 0.
REQ-024 DECODE: alusrca=0, alusrcb=11, alucont=010 (branch-target precompute).
REQ-025 DECODE: dispatch LB/LW/SB/SW to MEMADR; RTYPE to RTYPEEX; BEQ/BNE to BREX; ADDI/ANDI/ORI to IMMEX; J to JEX.
REQ-026 DECODE, any other opcode: go to FETCH and assert illegal for that one cycle.
REQ-027 Opcodes: LB 100000, LW 100011, SB 101000, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, J 000010.
REQ-028 MEMADR: alusrca=1, alusrcb=10, alucont=010; go to LDRD for loads, STWR for stores.
REQ-029 LDRD/STWR: iord=1; memread (LDRD) or memwrite (STWR) asserted.
REQ-030 Byte ops take 1 beat in LDRD/STWR; word ops take BEATS beats; beat advances only on mem_rdy.
REQ-031 LDRD goes to LDWB after its final beat; STWR goes to FETCH after its final beat.
REQ-032 LDWB: regwrite=1, memtoreg=1, regdst=0; then FETCH.
REQ-033 RTYPEEX: alusrca=1, alusrcb=00; alucont from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other funct gives 010.
REQ-034 RTYPEWB: regwrite=1, regdst=1, memtoreg=0; then FETCH.
REQ-035 BREX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01; pcwrite = zero for BEQ, !zero for BNE; then FETCH.
REQ-036 IMMEX: alusrca=1, alusrcb=10; alucont 010 for ADDI, 000 for ANDI, 001 for ORI; then IMMWB.
REQ-037 IMMWB: regwrite=1, regdst=0, memtoreg=0; then FETCH.
REQ-038 JEX: pcwrite=1, pcsrc=10; then FETCH.
REQ-039 imm_ext is zero-extended for ANDI/ORI and sign-extended otherwise; it is combinational from instr.
REQ-040 Every control output not listed for the current state is 0.

Reset
REQ-041 reset_n low forces state=FETCH and beat=0 immediately, including mid-fetch or mid-store; all strobes deassert, no partial write completes.
REQ-042 Reset values: memwrite, regwrite, pcwrite and illegal are 0; outputs then take the FETCH values.

Structure
REQ-043 The state encoding, opcode values, funct values and alucont codes live in a shared package/header used by all datapath control blocks.
REQ-044 A combinational sub-module alu_ctrl_gen maps state, opcode and funct to alucont.
REQ-045 State and beat are the only sequential elements.

Verification
REQ-046 WIDTH=8, ADD with mem_rdy=1 throughout -> irwrite 0001,0010,0100,1000, then DECODE, RTYPEEX (alucont=010), RTYPEWB (regwrite=1); 7 cycles total.
REQ-047 WIDTH=32, LW -> FETCH, DECODE, MEMADR, LDRD, LDWB, each 1 cycle; memtoreg=1 in LDWB.
REQ-048 WIDTH=8, mem_rdy=0 for 3 cycles during fetch beat 2 -> state and beat hold; irwrite=0 and pcwrite=0 during the stall.
REQ-049 BNE with zero=0 -> pcwrite=1 in BREX; BEQ with zero=0 -> pcwrite=0; ORI with imm 0x8000 -> imm_ext=0x00008000.
REQ-050 Opcode 111111, and with EXT_OPS=0 opcode 001100 -> illegal pulses for 1 cycle in DECODE, next state FETCH.
REQ-051 reset_n low during STWR beat 1 (WIDTH=16) -> memwrite=0 immediately; state=FETCH and beat=0 after release.

Source files
------------

// File: rtl/mcycle_decoder_pkg.sv
// rtl/mcycle_decoder_pkg.sv - shared state, opcode, funct and ALU codes for the multicycle decoder
package mcycle_decoder_pkg;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_LDRD    = 4'd3;
    localparam logic [3:0] S_LDWB    = 4'd4;
    localparam logic [3:0] S_STWR    = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BREX    = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_RTYPE,
        CLS_BRANCH,
        CLS_IMM,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    // BNE/ANDI/ORI only exist when the extended opcode set is built in.
    function automatic op_class_t classify(input logic [5:0] op, input logic ext);
        op_class_t cls;
        case (op)
            OP_LB, OP_LW, OP_SB, OP_SW: cls = CLS_MEM;
            OP_RTYPE:                   cls = CLS_RTYPE;
            OP_BEQ:                     cls = CLS_BRANCH;
            OP_BNE:                     cls = ext ? CLS_BRANCH : CLS_ILLEGAL;
            OP_ADDI:                    cls = CLS_IMM;
            OP_ANDI, OP_ORI:            cls = ext ? CLS_IMM : CLS_ILLEGAL;
            OP_J:                       cls = CLS_JUMP;
            default:                    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mcycle_decoder_alu_ctrl_gen.sv
// rtl/mcycle_decoder_alu_ctrl_gen.sv - combinational ALU operation select from state, opcode and funct
module alu_ctrl_gen
    import mcycle_decoder_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alucont
);

    always_comb begin
        alucont = 3'b000;
        case (state)
            S_FETCH, S_DECODE, S_MEMADR: alucont = ALU_ADD;
            S_BREX:                      alucont = ALU_SUB;
            S_RTYPEEX: begin
                case (funct)
                    FN_ADD:  alucont = ALU_ADD;
                    FN_SUB:  alucont = ALU_SUB;
                    FN_AND:  alucont = ALU_AND;
                    FN_OR:   alucont = ALU_OR;
                    FN_SLT:  alucont = ALU_SLT;
                    default: alucont = ALU_ADD;
                endcase
            end
            S_IMMEX: begin
                case (opcode)
                    OP_ANDI: alucont = ALU_AND;
                    OP_ORI:  alucont = ALU_OR;
                    default: alucont = ALU_ADD;
                endcase
            end
            default: alucont = 3'b000;
        endcase
    end

endmodule

// File: rtl/mcycle_decoder.sv
// rtl/mcycle_decoder.sv - multicycle instruction control FSM with multi-beat memory access
module mcycle_decoder
    import mcycle_decoder_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int EXT_OPS = 1,
    localparam int BEATS   = 32 / WIDTH,
    localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      instr,
    input  logic             mem_rdy,
    input  logic             zero,
    output logic [3:0]       state,
    output logic [BEATS-1:0] irwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             regdst,
    output logic             pcwrite,
    output logic [1:0]       pcsrc,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       alucont,
    output logic [31:0]      imm_ext,
    output logic [BW-1:0]    beat,
    output logic             illegal
);

    logic [3:0]       state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [5:0]       opcode, funct;
    op_class_t        cls;
    logic             mem_state, byte_op, store_op, last_beat;
    logic             memread_c, memwrite_c, regwrite_c, pcwrite_c, illegal_c;
    logic [BEATS-1:0] irwrite_c;
    logic             unused_rs_rt;

    assign opcode       = instr[31:26];
    assign funct        = instr[5:0];
    assign cls          = classify(opcode, EXT_OPS != 0);
    assign byte_op      = (opcode == OP_LB) || (opcode == OP_SB);
    assign store_op     = (opcode == OP_SB) || (opcode == OP_SW);
    assign unused_rs_rt = ^instr[25:16];

    assign mem_state = (state_q == S_FETCH) || (state_q == S_LDRD) || (state_q == S_STWR);
    // Fetch always moves a full word; data accesses are a single beat for byte ops.
    assign last_beat = (state_q != S_FETCH && byte_op) ? (beat_q == '0)
                                                       : (beat_q == BW'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (mem_state) begin
            if (mem_rdy) begin
                if (last_beat) begin
                    beat_d = '0;
                    case (state_q)
                        S_FETCH: state_d = S_DECODE;
                        S_LDRD:  state_d = S_LDWB;
                        default: state_d = S_FETCH;
                    endcase
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_DECODE: begin
                    case (cls)
                        CLS_MEM:    state_d = S_MEMADR;
                        CLS_RTYPE:  state_d = S_RTYPEEX;
                        CLS_BRANCH: state_d = S_BREX;
                        CLS_IMM:    state_d = S_IMMEX;
                        CLS_JUMP:   state_d = S_JEX;
                        default:    state_d = S_FETCH;
                    endcase
                end
                S_MEMADR:  state_d = store_op ? S_STWR : S_LDRD;
                S_RTYPEEX: state_d = S_RTYPEWB;
                S_IMMEX:   state_d = S_IMMWB;
                default:   state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        pcwrite_c  = 1'b0;
        illegal_c  = 1'b0;
        irwrite_c  = '0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        case (state_q)
            S_FETCH: begin
                memread_c = 1'b1;
                irwrite_c = mem_rdy ? (BEATS'(1'b1) << beat_q) : '0;
                alusrcb   = 2'b01;
                pcwrite_c = mem_rdy;
            end
            S_DECODE: begin
                alusrcb   = 2'b11;
                illegal_c = (cls == CLS_ILLEGAL);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_LDRD: begin
                iord      = 1'b1;
                memread_c = 1'b1;
            end
            S_LDWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 1'b1;
            end
            S_STWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
            end
            S_RTYPEEX: alusrca = 1'b1;
            S_RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst     = 1'b1;
            end
            S_BREX: begin
                alusrca   = 1'b1;
                pcsrc     = 2'b01;
                pcwrite_c = (opcode == OP_BNE) ? !zero : zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_IMMWB: regwrite_c = 1'b1;
            S_JEX: begin
                pcwrite_c = 1'b1;
                pcsrc     = 2'b10;
            end
            default: ;
        endcase
    end

    alu_ctrl_gen u_alu_ctrl_gen (
        .state   (state_q),
        .opcode  (opcode),
        .funct   (funct),
        .alucont (alucont)
    );

    // Strobes are cut by reset itself so an in-flight write cannot complete.
    assign memread  = memread_c  & reset_n;
    assign memwrite = memwrite_c & reset_n;
    assign regwrite = regwrite_c & reset_n;
    assign pcwrite  = pcwrite_c  & reset_n;
    assign illegal  = illegal_c  & reset_n;
    assign irwrite  = irwrite_c & {BEATS{reset_n}};

    assign imm_ext = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ? {16'h0000, instr[15:0]}
                                                                 : {{16{instr[15]}}, instr[15:0]};
    assign state   = state_q;
    assign beat    = beat_q;

endmodule

// File: tb/tb_mcycle_decoder.sv
// tb/tb_mcycle_decoder.sv - directed and randomized checks of mcycle_decoder in four configurations
module tb_mcycle_decoder;
    import mcycle_decoder_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [3:0][31:0] instr;
    logic [3:0]       mem_rdy, zero;
    logic [3:0][3:0]  st, irw;
    logic [3:0][1:0]  bt, pcsrc, alusrcb;
    logic [3:0][2:0]  alucont;
    logic [3:0][31:0] imm;
    logic [3:0]       memread, memwrite, iord, memtoreg, regwrite, regdst, pcwrite, alusrca, illegal;

    // Instances: 0 = WIDTH 8, 1 = WIDTH 16, 2 = WIDTH 32, 3 = WIDTH 8 without extended opcodes
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W   = (g == 1) ? 16 : (g == 2) ? 32 : 8;
        localparam int X   = (g == 3) ? 0 : 1;
        localparam int NB  = 32 / W;
        localparam int BWL = (NB > 1) ? $clog2(NB) : 1;
        logic [NB-1:0]  irw_l;
        logic [BWL-1:0] bt_l;
        mcycle_decoder #(.WIDTH(W), .EXT_OPS(X)) u_dut (
            .clk(clk), .reset_n(reset_n), .instr(instr[g]), .mem_rdy(mem_rdy[g]), .zero(zero[g]),
            .state(st[g]), .irwrite(irw_l), .memread(memread[g]), .memwrite(memwrite[g]),
            .iord(iord[g]), .memtoreg(memtoreg[g]), .regwrite(regwrite[g]), .regdst(regdst[g]),
            .pcwrite(pcwrite[g]), .pcsrc(pcsrc[g]), .alusrca(alusrca[g]), .alusrcb(alusrcb[g]),
            .alucont(alucont[g]), .imm_ext(imm[g]), .beat(bt_l), .illegal(illegal[g])
        );
        assign irw[g] = 4'(irw_l);
        assign bt[g]  = 2'(bt_l);
    end

    typedef struct packed {
        logic [3:0]  state;
        logic [1:0]  beat;
        logic [3:0]  irwrite;
        logic        memread, memwrite, iord, memtoreg, regwrite, regdst, pcwrite;
        logic [1:0]  pcsrc;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic [2:0]  alucont;
        logic        illegal;
        logic [31:0] imm_ext;
    } ctl_t;

    int nchk = 0;
    int nfail = 0;
    int q[4][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int beats_of(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Reference model: the whole cycle plan of one instruction as a list of (state, beat) steps.
    task automatic plan(input int i);
        logic [5:0] op;
        bit ext;
        int nb, n;
        op  = instr[i][31:26];
        ext = (i != 3);
        nb  = beats_of(i);
        n   = (op == OP_LB || op == OP_SB) ? 1 : nb;
        for (int b = 0; b < nb; b++) q[i].push_back(int'(S_FETCH) * 16 + b);
        q[i].push_back(int'(S_DECODE) * 16);
        if (op == OP_LB || op == OP_LW) begin
            q[i].push_back(int'(S_MEMADR) * 16);
            for (int b = 0; b < n; b++) q[i].push_back(int'(S_LDRD) * 16 + b);
            q[i].push_back(int'(S_LDWB) * 16);
        end else if (op == OP_SB || op == OP_SW) begin
            q[i].push_back(int'(S_MEMADR) * 16);
            for (int b = 0; b < n; b++) q[i].push_back(int'(S_STWR) * 16 + b);
        end else if (op == OP_RTYPE) begin
            q[i].push_back(int'(S_RTYPEEX) * 16);
            q[i].push_back(int'(S_RTYPEWB) * 16);
        end else if (op == OP_BEQ || (op == OP_BNE && ext)) begin
            q[i].push_back(int'(S_BREX) * 16);
        end else if (op == OP_ADDI || ((op == OP_ANDI || op == OP_ORI) && ext)) begin
            q[i].push_back(int'(S_IMMEX) * 16);
            q[i].push_back(int'(S_IMMWB) * 16);
        end else if (op == OP_J) begin
            q[i].push_back(int'(S_JEX) * 16);
        end
    endtask

    function automatic ctl_t expect_ctl(input int i, input int item);
        ctl_t e;
        logic [5:0] op;
        logic [15:0] im;
        op = instr[i][31:26];
        im = instr[i][15:0];
        e = '0;
        e.state = 4'(item / 16);
        e.beat  = 2'(item % 16);
        e.imm_ext = (op == OP_ANDI || op == OP_ORI) ? {16'h0, im} : {{16{im[15]}}, im};
        case (e.state)
            S_FETCH:   begin e.memread = 1; e.alusrcb = 2'b01; e.alucont = ALU_ADD;
                             e.pcwrite = mem_rdy[i]; e.irwrite = mem_rdy[i] ? 4'(1 << e.beat) : 4'h0; end
            S_DECODE:  begin e.alusrcb = 2'b11; e.alucont = ALU_ADD; e.illegal = (q[i].size() == 1); end
            S_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucont = ALU_ADD; end
            S_LDRD:    begin e.iord = 1; e.memread = 1; end
            S_LDWB:    begin e.regwrite = 1; e.memtoreg = 1; end
            S_STWR:    begin e.iord = 1; e.memwrite = 1; end
            S_RTYPEEX: begin e.alusrca = 1; e.alucont = rtype_alu(instr[i][5:0]); end
            S_RTYPEWB: begin e.regwrite = 1; e.regdst = 1; end
            S_BREX:    begin e.alusrca = 1; e.alucont = ALU_SUB; e.pcsrc = 2'b01;
                             e.pcwrite = (op == OP_BNE) ? !zero[i] : zero[i]; end
            S_IMMEX:   begin e.alusrca = 1; e.alusrcb = 2'b10;
                             e.alucont = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_ADD; end
            S_IMMWB:   e.regwrite = 1;
            S_JEX:     begin e.pcwrite = 1; e.pcsrc = 2'b10; end
            default:   ;
        endcase
        return e;
    endfunction

    task automatic check_all(input int i, input ctl_t e);
        string p;
        p = $sformatf("rnd%0d.", i);
        chk({p, "state"},    32'(st[i]),       32'(e.state));
        chk({p, "beat"},     32'(bt[i]),       32'(e.beat));
        chk({p, "irwrite"},  32'(irw[i]),      32'(e.irwrite));
        chk({p, "memread"},  32'(memread[i]),  32'(e.memread));
        chk({p, "memwrite"}, 32'(memwrite[i]), 32'(e.memwrite));
        chk({p, "iord"},     32'(iord[i]),     32'(e.iord));
        chk({p, "memtoreg"}, 32'(memtoreg[i]), 32'(e.memtoreg));
        chk({p, "regwrite"}, 32'(regwrite[i]), 32'(e.regwrite));
        chk({p, "regdst"},   32'(regdst[i]),   32'(e.regdst));
        chk({p, "pcwrite"},  32'(pcwrite[i]),  32'(e.pcwrite));
        chk({p, "pcsrc"},    32'(pcsrc[i]),    32'(e.pcsrc));
        chk({p, "alusrca"},  32'(alusrca[i]),  32'(e.alusrca));
        chk({p, "alusrcb"},  32'(alusrcb[i]),  32'(e.alusrcb));
        chk({p, "alucont"},  32'(alucont[i]),  32'(e.alucont));
        chk({p, "illegal"},  32'(illegal[i]),  32'(e.illegal));
        chk({p, "imm_ext"},  32'(imm[i]),      32'(e.imm_ext));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [14];
        logic [5:0] fns [6];
        logic [31:0] r;
        ops = '{OP_LB, OP_LW, OP_SB, OP_SW, OP_RTYPE, OP_RTYPE, OP_BEQ, OP_BNE,
                OP_ADDI, OP_ANDI, OP_ORI, OP_J, 6'b111111, 6'b010101};
        fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, 6'b000111};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 13)];
        if (r[31:26] == OP_RTYPE) r[5:0] = fns[$urandom_range(0, 5)];
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        instr = '0; mem_rdy = '0; zero = '0;
        repeat (2) @(negedge clk);
        mem_rdy = '1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset.state", 32'(st[i]), 32'(S_FETCH));
            chk("reset.beat", 32'(bt[i]), 32'd0);
            chk("reset.pcwrite", 32'(pcwrite[i]), 32'd0);
            chk("reset.memwrite", 32'(memwrite[i]), 32'd0);
            chk("reset.regwrite", 32'(regwrite[i]), 32'd0);
            chk("reset.illegal", 32'(illegal[i]), 32'd0);
            chk("reset.irwrite", 32'(irw[i]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mem_rdy = '0;

        // ADD at WIDTH 8: four fetch beats, decode, execute, writeback
        instr[0] = {OP_RTYPE, 20'h0, FN_ADD};
        mem_rdy[0] = 1'b1;
        #1;
        for (int b = 0; b < 4; b++) begin
            chk("add.fetch.state", 32'(st[0]), 32'(S_FETCH));
            chk("add.fetch.irwrite", 32'(irw[0]), 32'(1 << b));
            chk("add.fetch.pcwrite", 32'(pcwrite[0]), 32'd1);
            tick();
        end
        chk("add.decode", 32'(st[0]), 32'(S_DECODE));
        chk("add.decode.alusrcb", 32'(alusrcb[0]), 32'd3);
        tick();
        chk("add.ex", 32'(st[0]), 32'(S_RTYPEEX));
        chk("add.ex.alucont", 32'(alucont[0]), 32'(ALU_ADD));
        tick();
        chk("add.wb", 32'(st[0]), 32'(S_RTYPEWB));
        chk("add.wb.regwrite", 32'(regwrite[0]), 32'd1);
        chk("add.wb.regdst", 32'(regdst[0]), 32'd1);
        tick();
        chk("add.back_to_fetch", 32'(st[0]), 32'(S_FETCH));

        // SUB with a three-cycle stall on fetch beat 2
        instr[0] = {OP_RTYPE, 20'h0, FN_SUB};
        tick();
        chk("stall.beat1", 32'(bt[0]), 32'd1);
        @(negedge clk);
        mem_rdy[0] = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("stall.state", 32'(st[0]), 32'(S_FETCH));
            chk("stall.beat", 32'(bt[0]), 32'd2);
            chk("stall.irwrite", 32'(irw[0]), 32'd0);
            chk("stall.pcwrite", 32'(pcwrite[0]), 32'd0);
            tick();
        end
        mem_rdy[0] = 1'b1;
        #1;
        chk("stall.resume.irwrite", 32'(irw[0]), 32'h4);
        tick();
        chk("stall.beat3.irwrite", 32'(irw[0]), 32'h8);
        tick();
        chk("stall.decode", 32'(st[0]), 32'(S_DECODE));
        tick();
        chk("sub.ex.alucont", 32'(alucont[0]), 32'(ALU_SUB));
        @(negedge clk);
        mem_rdy[0] = 1'b0;

        // WIDTH 32 LW: one cycle per state
        instr[2] = {OP_LW, 26'h0010};
        mem_rdy[2] = 1'b1;
        #1;
        chk("lw.fetch.irwrite", 32'(irw[2]), 32'd1);
        tick();
        chk("lw.decode", 32'(st[2]), 32'(S_DECODE));
        tick();
        chk("lw.memadr", 32'(st[2]), 32'(S_MEMADR));
        chk("lw.memadr.alusrcb", 32'(alusrcb[2]), 32'd2);
        tick();
        chk("lw.ldrd", 32'(st[2]), 32'(S_LDRD));
        chk("lw.ldrd.iord", 32'(iord[2]), 32'd1);
        tick();
        chk("lw.ldwb", 32'(st[2]), 32'(S_LDWB));
        chk("lw.ldwb.memtoreg", 32'(memtoreg[2]), 32'd1);
        chk("lw.ldwb.regwrite", 32'(regwrite[2]), 32'd1);
        tick();
        chk("lw.fetch", 32'(st[2]), 32'(S_FETCH));

        // Branches with zero=0, then BEQ taken
        for (int k = 0; k < 3; k++) begin
            instr[2] = {(k == 0) ? OP_BNE : OP_BEQ, 10'h0, 16'h0004};
            zero[2] = (k == 2);
            tick();
            tick();
            chk("br.state", 32'(st[2]), 32'(S_BREX));
            chk("br.pcsrc", 32'(pcsrc[2]), 32'd1);
            chk("br.pcwrite", 32'(pcwrite[2]), (k == 1) ? 32'd0 : 32'd1);
            tick();
        end

        // ORI zero-extends, ADDI sign-extends the same immediate
        instr[2] = {OP_ORI, 10'h0, 16'h8000};
        #1;
        chk("ori.imm_ext", imm[2], 32'h0000_8000);
        tick();
        tick();
        chk("ori.alucont", 32'(alucont[2]), 32'(ALU_OR));
        tick();
        chk("ori.immwb", 32'(regwrite[2]), 32'd1);
        instr[2] = {OP_ADDI, 10'h0, 16'h8000};
        #1;
        chk("addi.imm_ext", imm[2], 32'hFFFF_8000);
        tick();

        // Undecodable opcode
        instr[2] = {6'b111111, 26'h0};
        tick();
        chk("ill.decode.illegal", 32'(illegal[2]), 32'd1);
        tick();
        chk("ill.next.state", 32'(st[2]), 32'(S_FETCH));
        chk("ill.next.illegal", 32'(illegal[2]), 32'd0);
        mem_rdy[2] = 1'b0;

        // ANDI without extended opcodes is illegal
        instr[3] = {OP_ANDI, 26'h0};
        mem_rdy[3] = 1'b1;
        for (int b = 0; b < 4; b++) tick();
        chk("noext.decode", 32'(st[3]), 32'(S_DECODE));
        chk("noext.illegal", 32'(illegal[3]), 32'd1);
        tick();
        chk("noext.next", 32'(st[3]), 32'(S_FETCH));
        mem_rdy[3] = 1'b0;

        // WIDTH 16 SW interrupted by reset on beat 1
        instr[1] = {OP_SW, 26'h0};
        mem_rdy[1] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("sw.stwr.b0", 32'(st[1]), 32'(S_STWR));
        @(negedge clk);
        mem_rdy[1] = 1'b0;
        #1;
        chk("sw.stwr.beat", 32'(bt[1]), 32'd1);
        chk("sw.stwr.memwrite", 32'(memwrite[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("sw.reset.memwrite", 32'(memwrite[1]), 32'd0);
        chk("sw.reset.state", 32'(st[1]), 32'(S_FETCH));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("sw.release.state", 32'(st[1]), 32'(S_FETCH));
        chk("sw.release.beat", 32'(bt[1]), 32'd0);

        // Randomized instruction streams against the plan model
        @(negedge clk);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (q[i].size() == 0) begin
                    instr[i] = rand_instr();
                    plan(i);
                end
                mem_rdy[i] = ($urandom_range(0, 3) != 0);
                zero[i] = 1'($urandom);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                int item;
                logic [3:0] s;
                item = q[i][0];
                check_all(i, expect_ctl(i, item));
                s = 4'(item / 16);
                if (!((s == S_FETCH || s == S_LDRD || s == S_STWR) && !mem_rdy[i]))
                    void'(q[i].pop_front());
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
